// File: rtl/nested_array_pkg.sv
// Shared constants, frame types, FSM state encoding and element-select helper
// for the nested array serializer.
package nested_array_pkg;

   localparam int N     = 10;
   localparam int W     = 10;
   localparam int IDX_W = $clog2(N);

   typedef struct packed {
      logic [W-1:0] x;
   } elem_t;

   // Element k lives at bits [k*W +: W], matching the flattened input frame.
   typedef elem_t [N-1:0] frame_t;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   // Explicit mux over the N legal indices; out-of-range codes read as zero.
   function automatic logic [W-1:0] frame_slice(input frame_t frame,
                                                input logic [IDX_W-1:0] idx);
      logic [W-1:0] r;
      r = '0;
      for (int k = 0; k < N; k++) begin
         if (idx == IDX_W'(k)) r = frame[k].x;
      end
      return r;
   endfunction

endpackage

// File: rtl/frame_reg.sv
// N*W-bit enable register holding one frame, synchronously cleared on reset.
module frame_reg
   import nested_array_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   en,
   input  frame_t d,
   output frame_t q
);

   always_ff @(posedge clk) begin
      if (reset)   q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/nested_array_serializer.sv
// Frame-to-element serializer: one N*W frame in, N W-bit beats out, element 0 first.
// Optional macro NESTED_ARRAY_SERIALIZER_PARITY_EN adds O_parity and sticky O_overrun.
module nested_array_serializer
   import nested_array_pkg::*;
(
   input  logic             CLK,
   input  logic             RESET,
   input  logic             I_valid,
   output logic             I_ready,
   input  logic [N*W-1:0]   I_data,
   output logic             O_valid,
   input  logic             O_ready,
   output logic [W-1:0]     O_data,
   output logic [IDX_W-1:0] O_index,
`ifdef NESTED_ARRAY_SERIALIZER_PARITY_EN
   output logic             O_parity,
   output logic             O_overrun,
`endif
   output logic             O_last
);

   state_t           state, state_n;
   logic [IDX_W-1:0] idx, idx_n;
   frame_t           frame;
   logic             is_last;
   logic             take;

   frame_reg u_frame_reg (
      .clk   (CLK),
      .reset (RESET),
      .en    (take),
      .d     (frame_t'(I_data)),
      .q     (frame)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
      end
   end

   // I_ready depends combinationally on O_ready on the last beat (zero-bubble handoff).
   always_comb begin
      state_n = state;
      idx_n   = idx;
      is_last = (state == STREAM) && (idx == IDX_W'(N-1));
      I_ready = (state == IDLE) || (is_last && O_ready);
      take    = I_valid && I_ready;
      O_valid = (state == STREAM) && !RESET;
      O_index = idx;
      O_last  = is_last && O_valid;
      O_data  = O_valid ? frame_slice(frame, idx) : '0;

      case (state)
         IDLE: begin
            if (I_valid) begin
               state_n = STREAM;
               idx_n   = '0;
            end
         end
         STREAM: begin
            if (O_ready) begin
               if (!is_last) begin
                  idx_n = idx + 1'b1;
               end else begin
                  idx_n   = '0;
                  state_n = I_valid ? STREAM : IDLE;
               end
            end
         end
         default: begin
            state_n = IDLE;
            idx_n   = '0;
         end
      endcase
   end

`ifdef NESTED_ARRAY_SERIALIZER_PARITY_EN
   logic stall, stall_prev;

   assign stall    = I_valid && !I_ready;
   assign O_parity = O_valid ? ^O_data : 1'b0;

   // Overrun flags an upstream that keeps pushing through two or more refused cycles.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         stall_prev <= 1'b0;
         O_overrun  <= 1'b0;
      end else begin
         stall_prev <= stall;
         if (stall && stall_prev) O_overrun <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_nested_array_serializer.sv
// Scoreboard bench for nested_array_serializer: directed frames, backpressure,
// back-to-back handoff, mid-stream reset and optional parity/overrun.
module tb_nested_array_serializer;
   import nested_array_pkg::*;

   logic             CLK = 1'b0;
   logic             RESET;
   logic             I_valid;
   logic             I_ready;
   logic [N*W-1:0]   I_data;
   logic             O_valid;
   logic             O_ready;
   logic [W-1:0]     O_data;
   logic [IDX_W-1:0] O_index;
   logic             O_last;
`ifdef NESTED_ARRAY_SERIALIZER_PARITY_EN
   logic             O_parity;
   logic             O_overrun;
`endif

   nested_array_serializer dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .I_valid (I_valid),
      .I_ready (I_ready),
      .I_data  (I_data),
      .O_valid (O_valid),
      .O_ready (O_ready),
      .O_data  (O_data),
      .O_index (O_index),
`ifdef NESTED_ARRAY_SERIALIZER_PARITY_EN
      .O_parity  (O_parity),
      .O_overrun (O_overrun),
`endif
      .O_last  (O_last)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [W-1:0]     d;
      logic [IDX_W-1:0] i;
      logic             l;
   } beat_t;

   beat_t exp_q[$];
   int    n_cmp  = 0;
   int    n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [N*W-1:0] mk_frame(input int mode);
      logic [N*W-1:0] f;
      f = '0;
      for (int k = 0; k < N; k++) begin
         case (mode)
            0: f[k*W +: W] = W'(k + 1);
            1: f[k*W +: W] = 10'h3FF;
            2: f[k*W +: W] = 10'h001;
            3: f[k*W +: W] = 10'h155;
            default: f[k*W +: W] = (k == 0) ? 10'h007 : (k == 1) ? 10'h003 : W'(k);
         endcase
      end
      return f;
   endfunction

   task automatic push_frame(input logic [N*W-1:0] f, input int count);
      beat_t b;
      for (int k = 0; k < count; k++) begin
         b.d = f[k*W +: W];
         b.i = IDX_W'(k);
         b.l = (k == N-1);
         exp_q.push_back(b);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Returns cycles taken for the scoreboard to drain; expiry is a failed comparison.
   task automatic wait_empty(input string name, output int n);
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0) check({name, "_timeout"}, exp_q.size(), 0);
   endtask

   task automatic wait_index(input int target);
      int n;
      n = 0;
      while (!(O_valid && O_index == IDX_W'(target)) && n < 60) begin
         tick();
         n++;
      end
      if (n >= 60) check("wait_index_timeout", int'(O_index), target);
   endtask

   // Monitor: every accepted beat is popped from the scoreboard and compared.
   always @(negedge CLK) begin
      beat_t e;
      if (!RESET && O_valid && O_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", int'(O_data), -1);
         end else begin
            e = exp_q.pop_front();
            check("beat_data",  int'(O_data),  int'(e.d));
            check("beat_index", int'(O_index), int'(e.i));
            check("beat_last",  int'(O_last),  int'(e.l));
         end
      end
   end

   initial begin
      int n;
      RESET   = 1'b1;
      I_valid = 1'b0;
      O_ready = 1'b0;
      I_data  = '0;
      tick();
      tick();
      check("rst_o_valid", int'(O_valid), 0);
      check("rst_o_data",  int'(O_data),  0);
      check("rst_o_index", int'(O_index), 0);
      check("rst_o_last",  int'(O_last),  0);
      check("rst_i_ready", int'(I_ready), 1);
      RESET = 1'b0;
      tick();

      // Single frame, no backpressure.
      I_data  = mk_frame(0);
      I_valid = 1'b1;
      O_ready = 1'b1;
      check("single_i_ready_idle", int'(I_ready), 1);
      push_frame(mk_frame(0), N);
      tick();
      I_valid = 1'b0;
      wait_empty("single", n);
      check("single_cycles", n, N);
      check("single_idle_o_valid", int'(O_valid), 0);
      check("single_idle_i_ready", int'(I_ready), 1);

      // Backpressure at index 4.
      I_valid = 1'b1;
      push_frame(mk_frame(0), N);
      tick();
      I_valid = 1'b0;
      wait_index(4);
      O_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("bp_o_valid", int'(O_valid), 1);
         check("bp_o_data",  int'(O_data),  5);
         check("bp_o_index", int'(O_index), 4);
         check("bp_i_ready", int'(I_ready), 0);
         tick();
      end
      O_ready = 1'b1;
      check("bp_resume_index", int'(O_index), 4);
      tick();
      check("bp_next_index", int'(O_index), 5);
      check("bp_next_data",  int'(O_data),  6);
      wait_empty("bp", n);

      // Back-to-back frames with no bubble.
      I_data  = mk_frame(1);
      I_valid = 1'b1;
      push_frame(mk_frame(1), N);
      tick();
      I_data = mk_frame(2);
      push_frame(mk_frame(2), N);
      for (int i = 0; i < 2*N; i++) begin
         check("b2b_o_valid", int'(O_valid), 1);
         check("b2b_i_ready", int'(I_ready), (i % N == N-1) ? 1 : 0);
         tick();
         if (i == N-1) I_valid = 1'b0;
      end
      check("b2b_end_o_valid", int'(O_valid), 0);
      check("b2b_queue_left", exp_q.size(), 0);

      // Reset at index 6: beats 0..5 consumed, remainder discarded.
      I_data  = mk_frame(0);
      I_valid = 1'b1;
      push_frame(mk_frame(0), 6);
      tick();
      I_valid = 1'b0;
      wait_index(6);
      RESET = 1'b1;
      #1;
      check("midrst_cycle_o_valid", int'(O_valid), 0);
      tick();
      RESET = 1'b0;
      check("midrst_o_valid", int'(O_valid), 0);
      check("midrst_i_ready", int'(I_ready), 1);
      check("midrst_o_index", int'(O_index), 0);
      check("midrst_queue_left", exp_q.size(), 0);
      I_data  = mk_frame(3);
      I_valid = 1'b1;
      push_frame(mk_frame(3), N);
      tick();
      I_valid = 1'b0;
      check("after_rst_first_data", int'(O_data), 10'h155);
      wait_empty("after_rst", n);
      check("after_rst_cycles", n, N);

`ifdef NESTED_ARRAY_SERIALIZER_PARITY_EN
      // Parity and overrun with I_valid held high through a stream.
      check("par_idle", int'(O_parity), 0);
      check("ovr_initial", int'(O_overrun), 0);
      O_ready = 1'b0;
      I_data  = mk_frame(4);
      I_valid = 1'b1;
      push_frame(mk_frame(4), N);
      push_frame(mk_frame(4), N);
      tick();
      check("par_007", int'(O_parity), 1);
      tick();
      O_ready = 1'b1;
      tick();
      check("par_003", int'(O_parity), 0);
      check("ovr_set", int'(O_overrun), 1);
      wait_index(N-1);
      tick();
      I_valid = 1'b0;
      wait_empty("par", n);
      check("ovr_sticky", int'(O_overrun), 1);
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      check("ovr_cleared", int'(O_overrun), 0);
      check("par_after_rst", int'(O_parity), 0);
`endif

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
